// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and window tap addressing for the 3x3 window feeder.
package conv_pkg;
  localparam int PIX_W = 8;
  localparam int TAPS  = 9;
  localparam int WIN_W = PIX_W * TAPS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WRITE  = 2'd2,
    STREAM = 2'd3
  } state_t;

  // LSB position of window/filter tap (r, c), r=0 top row, c=0 leftmost column.
  function automatic int tap_lsb(input int r, input int c);
    return PIX_W * (3 * r + c);
  endfunction
endpackage

// File: rtl/conv3x3_line_buffer.sv
// Two one-row pixel delay lines; row1 holds the row above row0 at the same column.
module conv3x3_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 16
) (
  input  logic                       clk,
  input  logic                       shift_en,
  input  logic [$clog2(IMG_W)-1:0]   col,
  input  logic [PIX_W-1:0]           din,
  output logic [PIX_W-1:0]           rd0,
  output logic [PIX_W-1:0]           rd1
);
  logic [PIX_W-1:0] row0 [IMG_W];
  logic [PIX_W-1:0] row1 [IMG_W];

  assign rd0 = row0[col];
  assign rd1 = row1[col];

  // Push the accepted pixel down one row at the current column.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      row1[col] <= row0[col];
      row0[col] <= din;
    end
  end
endmodule

// File: rtl/conv3x3_window_feeder.sv
// Serial filter loader and raster-to-3x3-window converter feeding the conv PE tensor.
module conv3x3_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             filt_in_valid,
  input  logic [PIX_W-1:0] filt_in_data,
  output logic             filt_in_ready,
  input  logic             pix_in_valid,
  input  logic [PIX_W-1:0] pix_in_data,
  output logic             pix_in_ready,
  output logic             wb_write_en,
  output logic [WIN_W-1:0] filter,
  output logic [WIN_W-1:0] ifmap,
  output logic             ifmap_valid,
  output logic             frame_done
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t           state;
  state_t           next_state;
  logic             filt_loaded;
  logic [3:0]       idx;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             filt_acc;
  logic             pix_acc;
  logic             last_pix;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] win_next;

  // Readies are registered, so a handshake is only seen in states that raised them.
  assign filt_acc = filt_in_valid & filt_in_ready;
  assign pix_acc  = pix_in_valid & pix_in_ready;
  assign last_pix = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

  conv3x3_line_buffer #(.IMG_W(IMG_W)) u_line_buffer (
    .clk      (clk),
    .shift_en (pix_acc),
    .col      (col),
    .din      (pix_in_data),
    .rd0      (lb0_rd),
    .rd1      (lb1_rd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (filt_acc) begin
          next_state = LOAD;
        end else if (filt_loaded && pix_in_valid) begin
          next_state = STREAM;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        if (filt_acc && (idx == 4'd8)) begin
          next_state = WRITE;
        end else begin
          next_state = LOAD;
        end
      end
      WRITE:   next_state = IDLE;
      STREAM: begin
        if (pix_acc && last_pix) begin
          next_state = IDLE;
        end else begin
          next_state = STREAM;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Window after shifting left one column and inserting the new right column.
  always_comb begin
    win_next = win;
    for (int r = 0; r < 3; r++) begin
      win_next[tap_lsb(r, 0) +: PIX_W] = win[tap_lsb(r, 1) +: PIX_W];
      win_next[tap_lsb(r, 1) +: PIX_W] = win[tap_lsb(r, 2) +: PIX_W];
    end
    win_next[tap_lsb(0, 2) +: PIX_W] = lb1_rd;
    win_next[tap_lsb(1, 2) +: PIX_W] = lb0_rd;
    win_next[tap_lsb(2, 2) +: PIX_W] = pix_in_data;
  end

  // Filter collection, weight-buffer strobe and handshake readies.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= 4'd0;
      filter        <= '0;
      filt_loaded   <= 1'b0;
      wb_write_en   <= 1'b0;
      filt_in_ready <= 1'b0;
      pix_in_ready  <= 1'b0;
    end else begin
      wb_write_en   <= (state == WRITE);
      filt_in_ready <= (next_state == IDLE) || (next_state == LOAD);
      pix_in_ready  <= (next_state == STREAM);
      if (state == WRITE) begin
        filt_loaded <= 1'b1;
      end
      if (filt_acc && ((state == IDLE) || (state == LOAD))) begin
        filter[{idx, 3'b000} +: PIX_W] <= filt_in_data;
        idx <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
      end
    end
  end

  // Window registers, raster counters and per-pixel output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      win         <= '0;
      ifmap       <= '0;
      ifmap_valid <= 1'b0;
      frame_done  <= 1'b0;
      col         <= '0;
      row         <= '0;
    end else begin
      ifmap_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (pix_acc) begin
        win <= win_next;
        // Columns 0..1 of a row would mix in pixels from the previous row.
        if ((row >= ROW_W'(2)) && (col >= COL_W'(2))) begin
          ifmap       <= win_next;
          ifmap_valid <= 1'b1;
        end
        if (last_pix) begin
          col        <= '0;
          row        <= '0;
          frame_done <= 1'b1;
        end else if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end
endmodule
